// File: rtl/pwm_shadow_bank.sv
// Shadow register bank for the PWM compare/period path: per-channel staging
// registers are copied to the active outputs together on a selected carrier event.
module pwm_shadow_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pwm_onoff,
  input  logic [1:0]                mode,
  input  logic                      evt_zero,
  input  logic                      evt_period,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CW-1:0]             wr_chan,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      commit,
  input  logic                      clr_overrun,
  output logic [CHANNELS*WIDTH-1:0] reg_out,
  output logic [CHANNELS-1:0]       pending,
  output logic                      armed,
  output logic                      upd_done,
  output logic                      overrun
);

  localparam logic        PWM_ON = 1'b1;
  localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);

  logic [CHANNELS-1:0][WIDTH-1:0] staging_p0;
  logic [CHANNELS-1:0]            pending_p0;
  logic [CHANNELS-1:0]            pending_d;
  logic                           armed_p0;
  logic                           armed_d;
  logic                           overrun_p0;
  logic                           overrun_d;
  logic [CHANNELS-1:0][WIDTH-1:0] active_p1;
  logic                           upd_done_p1;
  logic                           chan_ok;
  logic                           wr_hit;
  logic                           xfer;

  // A transfer is allowed when the carrier is stopped, in immediate mode,
  // or when an event enabled by the mode bits fires this cycle.
  function automatic logic load_event(input logic [1:0] m, input logic on,
                                      input logic ez, input logic ep);
    return (on != PWM_ON) || (m == 2'b00) || (m[0] && ez) || (m[1] && ep);
  endfunction

  assign wr_ready = !armed_p0;
  assign chan_ok  = ({1'b0, wr_chan} < CH_LIM);
  assign wr_hit   = wr_valid && wr_ready && chan_ok;
  assign xfer     = armed_p0 && load_event(mode, pwm_onoff, evt_zero, evt_period);

  always_comb begin
    pending_d = pending_p0;
    if (xfer) begin
      pending_d = '0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_hit && (wr_chan == CW'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    armed_d = armed_p0;
    if (xfer) begin
      armed_d = 1'b0;
    end else if (commit && !armed_p0) begin
      armed_d = 1'b1;
    end
  end

  // Overrun set takes priority over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_p0;
    if (commit && armed_p0) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Stage 0: staging registers and control flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_p0 <= '0;
      armed_p0   <= 1'b0;
      overrun_p0 <= 1'b0;
    end else begin
      pending_p0 <= pending_d;
      armed_p0   <= armed_d;
      overrun_p0 <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staging_p0 <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit && (wr_chan == CW'(i))) begin
          staging_p0[i] <= wr_data;
        end
      end
    end
  end

  // Stage 1: active outputs, loaded atomically from pending staging slots
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_p1   <= '0;
      upd_done_p1 <= 1'b0;
    end else begin
      upd_done_p1 <= xfer;
      for (int i = 0; i < CHANNELS; i++) begin
        if (xfer && pending_p0[i]) begin
          active_p1[i] <= staging_p0[i];
        end
      end
    end
  end

  assign reg_out  = active_p1;
  assign pending  = pending_p0;
  assign armed    = armed_p0;
  assign upd_done = upd_done_p1;
  assign overrun  = overrun_p0;

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// Bench for pwm_shadow_bank: table of per-cycle vectors plus hand sequences;
// expected active images are queued at commit and checked on each upd_done.
module tb_pwm_shadow_bank;
  localparam int W  = 16;
  localparam int CH = 6;
  localparam int OW = CH * W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pwm_onoff;
  logic [1:0]    mode;
  logic          evt_zero, evt_period;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_chan;
  logic [W-1:0]  wr_data;
  logic          commit, clr_overrun;
  logic [OW-1:0] reg_out;
  logic [CH-1:0] pending;
  logic          armed, upd_done, overrun;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] sb[$];

  typedef struct {
    logic wv; logic [2:0] ch; logic [W-1:0] d; logic cm; logic [1:0] md;
    logic on; logic ez; logic ep; logic clr; logic push; logic [OW-1:0] img;
    logic e_arm; logic [CH-1:0] e_pend; logic e_upd; logic e_ovr;
  } vec_t;

  vec_t tbl[18];
  logic [OW-1:0] Z, I1, I2, I3, I4, I5, I6;

  pwm_shadow_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset_n(reset_n), .pwm_onoff(pwm_onoff), .mode(mode),
    .evt_zero(evt_zero), .evt_period(evt_period), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_data(wr_data), .commit(commit),
    .clr_overrun(clr_overrun), .reg_out(reg_out), .pending(pending),
    .armed(armed), .upd_done(upd_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] img6(input logic [W-1:0] c5, c4, c3, c2, c1, c0);
    return {c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic vec_t mk(input logic wv, input logic [2:0] ch, input logic [W-1:0] d,
                              input logic cm, input logic [1:0] md, input logic on,
                              input logic ez, input logic ep, input logic clr,
                              input logic push, input logic [OW-1:0] img,
                              input logic e_arm, input logic [CH-1:0] e_pend,
                              input logic e_upd, input logic e_ovr);
    vec_t v;
    v.wv = wv; v.ch = ch; v.d = d; v.cm = cm; v.md = md; v.on = on;
    v.ez = ez; v.ep = ep; v.clr = clr; v.push = push; v.img = img;
    v.e_arm = e_arm; v.e_pend = e_pend; v.e_upd = e_upd; v.e_ovr = e_ovr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    wr_valid = v.wv; wr_chan = v.ch; wr_data = v.d; commit = v.cm; mode = v.md;
    pwm_onoff = v.on; evt_zero = v.ez; evt_period = v.ep; clr_overrun = v.clr;
    if (v.push) sb.push_back(v.img);
    @(posedge clk);
    #1;
    chk({tag, " armed"}, OW'(armed), OW'(v.e_arm));
    chk({tag, " wr_ready"}, OW'(wr_ready), OW'(!v.e_arm));
    chk({tag, " pending"}, OW'(pending), OW'(v.e_pend));
    chk({tag, " upd_done"}, OW'(upd_done), OW'(v.e_upd));
    chk({tag, " overrun"}, OW'(overrun), OW'(v.e_ovr));
  endtask

  // Every transfer pulse must match the oldest outstanding expected image.
  always @(negedge clk) begin
    if (reset_n && upd_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd_done: got transfer, expected none");
      end else begin
        chk("xfer reg_out", reg_out, sb.pop_front());
        chk("xfer pending_clear", OW'(pending), '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    Z  = '0;
    I1 = img6(16'h0, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h1234);
    I2 = img6(16'h0, 16'h0A0A, 16'hBEEF, 16'h0, 16'h0, 16'h1234);
    I3 = img6(16'h0, 16'h0A0A, 16'hBEEF, 16'h0002, 16'h0, 16'h1234);
    I4 = img6(16'h0, 16'h0A0A, 16'hBEEF, 16'h0002, 16'h1111, 16'h1234);
    I5 = img6(16'h0, 16'h0A0A, 16'hBEEF, 16'h00FF, 16'h1111, 16'h1234);
    I6 = img6(16'h0002, 16'h0A0A, 16'hBEEF, 16'h00FF, 16'h1111, 16'h1234);

    //            wv ch  data      cm md     on ez ep clr push img  arm pend   upd ovr
    tbl[0]  = mk(1, 0, 16'h1234, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h01, 0, 0);
    tbl[1]  = mk(1, 3, 16'hBEEF, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h09, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0,    1, 2'b01, 1, 0, 0, 0, 1, I1, 1, 6'h09, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0,    0, 2'b01, 1, 0, 1, 0, 0, Z,  1, 6'h09, 0, 0);
    tbl[4]  = mk(0, 0, 16'h0,    0, 2'b01, 1, 1, 0, 0, 0, Z,  0, 6'h00, 1, 0);
    tbl[5]  = mk(0, 0, 16'h0,    0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h00, 0, 0);
    tbl[6]  = mk(1, 4, 16'h0A0A, 0, 2'b10, 1, 0, 0, 0, 0, Z,  0, 6'h10, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0,    1, 2'b10, 1, 1, 0, 0, 1, I2, 1, 6'h10, 0, 0);
    tbl[8]  = mk(1, 1, 16'h5555, 0, 2'b10, 1, 1, 0, 0, 0, Z,  1, 6'h10, 0, 0);
    tbl[9]  = mk(0, 0, 16'h0,    0, 2'b10, 1, 0, 1, 0, 0, Z,  0, 6'h00, 1, 0);
    tbl[10] = mk(1, 2, 16'h0002, 0, 2'b11, 1, 0, 0, 0, 0, Z,  0, 6'h04, 0, 0);
    tbl[11] = mk(0, 0, 16'h0,    1, 2'b11, 1, 0, 0, 0, 1, I3, 1, 6'h04, 0, 0);
    tbl[12] = mk(0, 0, 16'h0,    0, 2'b11, 1, 1, 1, 0, 0, Z,  0, 6'h00, 1, 0);
    tbl[13] = mk(0, 0, 16'h0,    0, 2'b11, 1, 0, 0, 0, 0, Z,  0, 6'h00, 0, 0);
    tbl[14] = mk(1, 1, 16'h1111, 0, 2'b00, 1, 0, 0, 0, 0, Z,  0, 6'h02, 0, 0);
    tbl[15] = mk(0, 0, 16'h0,    1, 2'b00, 1, 0, 0, 0, 1, I4, 1, 6'h02, 0, 0);
    tbl[16] = mk(0, 0, 16'h0,    0, 2'b00, 1, 0, 0, 0, 0, Z,  0, 6'h00, 1, 0);
    tbl[17] = mk(0, 0, 16'h0,    0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h00, 0, 0);

    reset_n = 1'b0;
    wr_valid = 0; wr_chan = 0; wr_data = 0; commit = 0; mode = 2'b01;
    pwm_onoff = 1; evt_zero = 0; evt_period = 0; clr_overrun = 0;
    #12;
    chk("reset reg_out", reg_out, '0);
    chk("reset flags", OW'({pending, armed, upd_done, overrun}), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset wr_ready", OW'(wr_ready), OW'(1));

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("v%0d", i));

    // PWM off: write and commit together, transfer two edges later
    apply(mk(1, 2, 16'h00FF, 1, 2'b01, 0, 0, 0, 0, 1, I5, 1, 6'h04, 0, 0), "off0");
    apply(mk(0, 0, 16'h0,    0, 2'b01, 0, 0, 0, 0, 0, Z,  0, 6'h00, 1, 0), "off1");
    apply(mk(0, 0, 16'h0,    0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h00, 0, 0), "off2");

    // Overrun: empty commit, double commit, clear, set-wins, single transfer
    apply(mk(0, 0, 16'h0, 1, 2'b01, 1, 0, 0, 0, 1, I5, 1, 6'h00, 0, 0), "ovr0");
    apply(mk(0, 0, 16'h0, 1, 2'b01, 1, 0, 0, 0, 0, Z,  1, 6'h00, 0, 1), "ovr1");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 0, 0, 0, 0, Z,  1, 6'h00, 0, 1), "ovr2");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 0, 0, 1, 0, Z,  1, 6'h00, 0, 0), "ovr3");
    apply(mk(0, 0, 16'h0, 1, 2'b01, 1, 0, 0, 1, 0, Z,  1, 6'h00, 0, 1), "ovr4");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 0, 0, 1, 0, Z,  1, 6'h00, 0, 0), "ovr5");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 1, 0, 0, 0, Z,  0, 6'h00, 1, 0), "ovr6");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h00, 0, 0), "ovr7");

    // Last write wins; out-of-range channels are discarded
    apply(mk(1, 5, 16'h0001, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h20, 0, 0), "lw0");
    apply(mk(1, 5, 16'h0002, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h20, 0, 0), "lw1");
    apply(mk(1, 7, 16'hDEAD, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h20, 0, 0), "lw2");
    apply(mk(1, 6, 16'hDEAD, 0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h20, 0, 0), "lw3");
    apply(mk(0, 0, 16'h0,    1, 2'b01, 1, 0, 0, 0, 1, I6, 1, 6'h20, 0, 0), "lw4");
    apply(mk(0, 0, 16'h0,    0, 2'b01, 1, 1, 0, 0, 0, Z,  0, 6'h00, 1, 0), "lw5");
    apply(mk(0, 0, 16'h0,    0, 2'b01, 1, 0, 0, 0, 0, Z,  0, 6'h00, 0, 0), "lw6");

    // Asynchronous reset while armed with pending data
    apply(mk(1, 0, 16'hFFFF, 0, 2'b01, 1, 0, 0, 0, 0, Z, 0, 6'h01, 0, 0), "rst0");
    apply(mk(0, 0, 16'h0,    1, 2'b01, 1, 0, 0, 0, 0, Z, 1, 6'h01, 0, 0), "rst1");
    apply(mk(0, 0, 16'h0,    1, 2'b01, 1, 0, 0, 0, 0, Z, 1, 6'h01, 0, 1), "rst2");
    commit = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst reg_out", reg_out, '0);
    chk("async_rst flags", OW'({pending, armed, upd_done, overrun}), '0);
    chk("async_rst wr_ready", OW'(wr_ready), OW'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 1, 0, 0, 0, Z, 0, 6'h00, 0, 0), "rst3");
    apply(mk(0, 0, 16'h0, 0, 2'b11, 1, 1, 1, 0, 0, Z, 0, 6'h00, 0, 0), "rst4");
    apply(mk(0, 0, 16'h0, 1, 2'b01, 1, 0, 0, 0, 1, Z, 1, 6'h00, 0, 0), "rst5");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 1, 0, 0, 0, Z, 0, 6'h00, 1, 0), "rst6");
    apply(mk(0, 0, 16'h0, 0, 2'b01, 1, 0, 0, 0, 0, Z, 0, 6'h00, 0, 0), "rst7");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", OW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
